// File: rtl/system_0_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module  : system_0_sysid_checker
// Purpose : Avalon-MM read master that sits directly in front of the system-ID
//           slave. After reset (when AUTO_START=1) or after a start pulse, it
//           reads word 0 (system ID) and then word 1 (build timestamp). Each
//           word is compared with its expected parameter. The captured words,
//           the pass/fail flags and the busy/done status are published for
//           boot/status logic. A bounded wait on waitrequest stops a missing
//           slave from hanging the sequence.
// Ports   :
//   clock            in   1   system clock; every register is in this domain
//   reset            in   1   synchronous, active-high reset
//   start            in   1   one-cycle pulse; starts a check; ignored if busy
//   avm_address      out  1   0 = ID word, 1 = timestamp word
//   avm_read         out  1   Avalon read request
//   avm_waitrequest  in   1   slave stall
//   avm_readdata     in   32  read data, valid READ_LATENCY cycles after accept
//   id_value         out  32  captured ID word
//   ts_value         out  32  captured timestamp word
//   id_ok            out  1   id_value == EXPECTED_ID (valid when done=1)
//   ts_ok            out  1   ts_value == EXPECTED_TS (valid when done=1)
//   timeout          out  1   a read stalled longer than TIMEOUT_CYCLES
//   busy             out  1   sequence in progress
//   done             out  1   sticky end-of-sequence flag
// Revision: 1.0 - initial release
// ============================================================================
module system_0_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h00000000,
  parameter logic [31:0] EXPECTED_TS    = 32'h639A7D4A,
  parameter int unsigned READ_LATENCY   = 0,    // 0..3
  parameter int unsigned TIMEOUT_CYCLES = 255,  // 1..65535
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic        busy,
  output logic        done
);

  localparam bit          LAT_ZERO = (READ_LATENCY == 0);
  localparam logic [1:0]  LAT_N    = 2'(READ_LATENCY);
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_ID = 3'd1,
    LAT_ID = 3'd2,
    REQ_TS = 3'd3,
    LAT_TS = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] wait_cnt;
  logic [1:0]  lat_cnt;
  logic        auto_pending;  // one-shot: first cycle after reset release
  logic        id_got;        // word actually captured (a timed-out word never passes)
  logic        ts_got;

  logic in_req;
  logic in_lat;
  logic on_ts;
  logic accept;
  logic expired;
  logic capture;

  always_comb begin
    in_req  = (state == REQ_ID) || (state == REQ_TS);
    in_lat  = (state == LAT_ID) || (state == LAT_TS);
    on_ts   = (state == REQ_TS) || (state == LAT_TS);
    accept  = in_req && !avm_waitrequest;
    expired = in_req && avm_waitrequest && (wait_cnt == TO_LIMIT);
    // Zero latency: data is taken in the accepting cycle itself.
    capture = LAT_ZERO ? accept : (in_lat && (lat_cnt == LAT_N));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      avm_address  <= 1'b0;
      avm_read     <= 1'b0;
      id_value     <= 32'd0;
      ts_value     <= 32'd0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wait_cnt     <= 16'd0;
      lat_cnt      <= 2'd0;
      id_got       <= 1'b0;
      ts_got       <= 1'b0;
      auto_pending <= AUTO_START;
    end else begin
      auto_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (start || auto_pending) begin
            state       <= REQ_ID;
            busy        <= 1'b1;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            id_got      <= 1'b0;
            ts_got      <= 1'b0;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            wait_cnt    <= 16'd0;
          end
        end

        REQ_ID, REQ_TS: begin
          if (accept) begin
            // Non-zero latency: release the bus and count to the data beat.
            if (!LAT_ZERO) begin
              avm_read <= 1'b0;
              lat_cnt  <= 2'd1;
              state    <= on_ts ? LAT_TS : LAT_ID;
            end
          end else if (expired) begin
            timeout  <= 1'b1;
            avm_read <= 1'b0;
            state    <= FIN;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        LAT_ID, LAT_TS: begin
          if (!capture) begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        FIN: begin
          id_ok <= id_got && (id_value == EXPECTED_ID);
          ts_ok <= ts_got && (ts_value == EXPECTED_TS);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          avm_read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase

      // Data beat: store the word and move on to the next read or to FIN.
      if (capture) begin
        if (on_ts) begin
          ts_value <= avm_readdata;
          ts_got   <= 1'b1;
          avm_read <= 1'b0;
          state    <= FIN;
        end else begin
          id_value    <= avm_readdata;
          id_got      <= 1'b1;
          avm_read    <= 1'b1;
          avm_address <= 1'b1;
          wait_cnt    <= 16'd0;
          state       <= REQ_TS;
        end
      end
    end
  end

endmodule
`default_nettype wire
